// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment driver for DIGITS BCD/hex nibbles.
// Refresh scan with guard blanking, leading-zero suppression, optional hex
// glyphs and configurable segment/anode polarity. All outputs are registered.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 2,
    parameter bit HEX_MODE       = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0]     GUARD_C  = CW'(GUARD);
    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [4*DIGITS-1:0] shadow_dig;
    logic [DIGITS-1:0]   shadow_dp;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;

    logic [3:0]          nib;
    logic                dp_sel;
    logic                upper_zero;
    logic                blank;
    logic [DIGITS-1:0]   an_vec;
    logic [6:0]          seg_hi;
    logic                dp_hi;
    logic [DIGITS-1:0]   an_hi;
    logic [6:0]          seg_d;
    logic                dp_d;
    logic [DIGITS-1:0]   an_d;

    // Active-high a..g glyph for one nibble; codes 10-15 depend on HEX_MODE.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        s = 7'b0000000;
        case (code)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = HEX_MODE ? 7'b1110111 : 7'b0000000;
            4'hB: s = HEX_MODE ? 7'b0011111 : 7'b0000000;
            4'hC: s = HEX_MODE ? 7'b1001110 : 7'b0000000;
            4'hD: s = HEX_MODE ? 7'b0111101 : 7'b0000000;
            4'hE: s = HEX_MODE ? 7'b1001111 : 7'b0000000;
            4'hF: s = HEX_MODE ? 7'b1000111 : 7'b0000000;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Shadow capture of the displayed value, independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_dig <= '0;
            shadow_dp  <= '0;
        end else if (load) begin
            shadow_dig <= digits_in;
            shadow_dp  <= dp_in;
        end
    end

    // Refresh counter, digit index and end-of-frame pulse; all hold while en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= en && (cnt == CNT_LAST) && (idx == IDX_LAST);
            if (en) begin
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Select the current digit, apply blanking, guard, enable and polarity.
    always_comb begin
        nib        = 4'd0;
        dp_sel     = 1'b0;
        an_vec     = '0;
        upper_zero = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib       = shadow_dig[4*k +: 4];
                dp_sel    = shadow_dp[k];
                an_vec[k] = 1'b1;
            end
            // Suppression looks at the current digit and everything above it.
            if ((IW'(k) >= idx) && (shadow_dig[4*k +: 4] != 4'd0))
                upper_zero = 1'b0;
        end
        blank  = lz_blank && (idx != '0) && upper_zero;
        seg_hi = (en && !blank) ? decode(nib) : 7'b0000000;
        dp_hi  = en && dp_sel;
        an_hi  = (en && (cnt >= GUARD_C)) ? an_vec : '0;
        seg_d  = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_d   = SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
        an_d   = AN_ACTIVE_LOW ? ~an_hi : an_hi;
    end

    // Output register; reset drives the post-polarity inactive levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= SEG_OFF;
            dp_out  <= DP_OFF;
            an_out  <= AN_OFF;
        end else begin
            seg_out <= seg_d;
            dp_out  <= dp_d;
            an_out  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed testbench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=8, GUARD=2).
// A second instance with HEX_MODE=1 shares all inputs for the hex glyph checks.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_blank;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        fd0, fd1;

    int checks = 0;
    int errors = 0;

    logic [6:0] pat  [4];
    logic [6:0] pat1 [4];

    seg7_scan_driver #(
        .DIGITS(4), .REFRESH_DIV(8), .GUARD(2),
        .HEX_MODE(1'b0), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .lz_blank(lz_blank),
        .seg_out(seg0), .dp_out(dp0), .an_out(an0), .frame_done(fd0)
    );

    seg7_scan_driver #(
        .DIGITS(4), .REFRESH_DIV(8), .GUARD(2),
        .HEX_MODE(1'b1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
    ) dut_hex (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .lz_blank(lz_blank),
        .seg_out(seg1), .dp_out(dp1), .an_out(an1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    // Reset, load the shadow with en=0, then enable; the next posedge is edge 1.
    task automatic start_scan(input logic [15:0] v, input logic [3:0] dpv, input logic lz);
        rst_n = 1'b0; en = 1'b0; load = 1'b0; lz_blank = lz;
        digits_in = '0; dp_in = '0;
        @(negedge clk);
        rst_n = 1'b1; load = 1'b1; digits_in = v; dp_in = dpv;
        @(negedge clk);
        load = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        start_scan(16'h0008, 4'b0001, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (an0 !== 4'b1110 || seg0 !== 7'b1111111 || dp0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre an=%b seg=%b dp=%b exp an=1110 seg=1111111 dp=1", an0, seg0, dp0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (seg0 !== 7'b0000000) begin errors++; $display("FAIL reset_seg got %b exp 0000000", seg0); end
        checks++; if (dp0 !== 1'b0) begin errors++; $display("FAIL reset_dp got %b exp 0", dp0); end
        checks++; if (an0 !== 4'b1111) begin errors++; $display("FAIL reset_an got %b exp 1111", an0); end
        checks++; if (fd0 !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", fd0); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            checks++;
            if (an0 !== ((n < 3) ? 4'b1111 : 4'b1110)) begin
                errors++; $display("FAIL reset_restart_an n=%0d got %b", n, an0);
            end
            checks++;
            if (seg0 !== 7'b1111110) begin
                errors++; $display("FAIL reset_restart_seg n=%0d got %b exp 1111110", n, seg0);
            end
        end
    endtask

    task automatic test_scan();
        int c, d, fd_cnt;
        logic [3:0] exp_an;
        pat[0] = 7'b0110011; pat[1] = 7'b1111001; pat[2] = 7'b1101101; pat[3] = 7'b0110000;
        fd_cnt = 0;
        start_scan(16'h1234, 4'b0000, 1'b0);
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            c = (n - 1) % 8;
            d = ((n - 1) / 8) % 4;
            exp_an = (c < 2) ? 4'b1111 : ~(4'b0001 << d);
            checks++;
            if (an0 !== exp_an) begin errors++; $display("FAIL scan_an n=%0d got %b exp %b", n, an0, exp_an); end
            checks++;
            if (seg0 !== pat[d]) begin errors++; $display("FAIL scan_seg n=%0d got %b exp %b", n, seg0, pat[d]); end
            checks++;
            if (fd0 !== (c == 7 && d == 3)) begin
                errors++; $display("FAIL scan_frame_done n=%0d got %b exp %b", n, fd0, (c == 7 && d == 3));
            end
            if (fd0 === 1'b1) fd_cnt++;
        end
        checks++;
        if (fd_cnt != 2) begin errors++; $display("FAIL scan_frame_count got %0d exp 2", fd_cnt); end
    endtask

    task automatic test_load_switch();
        start_scan(16'h1234, 4'b0000, 1'b0);
        repeat (7) @(negedge clk);
        load = 1'b1; digits_in = 16'h5678;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (seg0 !== 7'b0110011 || an0 !== 4'b1110) begin
            errors++; $display("FAIL switch_old got seg=%b an=%b exp seg=0110011 an=1110", seg0, an0);
        end
        @(negedge clk);
        checks++;
        if (seg0 !== 7'b1110000 || an0 !== 4'b1111) begin
            errors++; $display("FAIL switch_new got seg=%b an=%b exp seg=1110000 an=1111", seg0, an0);
        end
    endtask

    task automatic test_lz();
        int c, d;
        logic [3:0] exp_an;
        pat[0] = 7'b1111110; pat[1] = 7'b1011011; pat[2] = 7'b0000000; pat[3] = 7'b0000000;
        start_scan(16'h0050, 4'b1000, 1'b1);
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            c = (n - 1) % 8;
            d = (n - 1) / 8;
            exp_an = (c < 2) ? 4'b1111 : ~(4'b0001 << d);
            checks++;
            if (seg0 !== pat[d] || an0 !== exp_an) begin
                errors++; $display("FAIL lz50 n=%0d got seg=%b an=%b exp seg=%b an=%b", n, seg0, an0, pat[d], exp_an);
            end
            checks++;
            if (dp0 !== (d == 3)) begin errors++; $display("FAIL lz50_dp n=%0d got %b exp %b", n, dp0, (d == 3)); end
        end
        pat[1] = 7'b0000000;
        start_scan(16'h0000, 4'b0000, 1'b1);
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            d = (n - 1) / 8;
            checks++;
            if (seg0 !== pat[d]) begin errors++; $display("FAIL lz00 n=%0d got %b exp %b", n, seg0, pat[d]); end
        end
    endtask

    task automatic test_hex();
        int d;
        pat[0]  = 7'b0000000; pat[1]  = 7'b0000000; pat[2]  = 7'b1111110; pat[3]  = 7'b1111110;
        pat1[0] = 7'b1000111; pat1[1] = 7'b1110111; pat1[2] = 7'b1111110; pat1[3] = 7'b1111110;
        start_scan(16'h00AF, 4'b0000, 1'b0);
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            d = (n - 1) / 8;
            checks++;
            if (seg0 !== pat[d]) begin errors++; $display("FAIL hex0 n=%0d got %b exp %b", n, seg0, pat[d]); end
            checks++;
            if (seg1 !== pat1[d]) begin errors++; $display("FAIL hex1 n=%0d got %b exp %b", n, seg1, pat1[d]); end
        end
    endtask

    task automatic test_enable();
        int c, d;
        logic [3:0] exp_an;
        start_scan(16'h1234, 4'b0100, 1'b0);
        for (int n = 1; n <= 21; n++) begin
            @(negedge clk);
            c = (n - 1) % 8;
            d = (n - 1) / 8;
            exp_an = (c < 2) ? 4'b1111 : ~(4'b0001 << d);
            checks++;
            if (dp0 !== (d == 2) || an0 !== exp_an) begin
                errors++; $display("FAIL en_run n=%0d got dp=%b an=%b exp dp=%b an=%b", n, dp0, an0, (d == 2), exp_an);
            end
        end
        en = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            checks++;
            if (an0 !== 4'b1111 || seg0 !== 7'b0000000 || dp0 !== 1'b0 || fd0 !== 1'b0) begin
                errors++; $display("FAIL en_off n=%0d got an=%b seg=%b dp=%b exp an=1111 seg=0000000 dp=0", n, an0, seg0, dp0);
            end
        end
        en = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (an0 !== 4'b1011 || seg0 !== 7'b1101101 || dp0 !== 1'b1) begin
                errors++; $display("FAIL en_resume n=%0d got an=%b seg=%b dp=%b exp an=1011 seg=1101101 dp=1", n, an0, seg0, dp0);
            end
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            exp_an = (n < 2) ? 4'b1111 : 4'b0111;
            checks++;
            if (an0 !== exp_an || seg0 !== 7'b0110000 || dp0 !== 1'b0) begin
                errors++; $display("FAIL en_next n=%0d got an=%b seg=%b dp=%b exp an=%b seg=0110000 dp=0", n, an0, seg0, dp0, exp_an);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; lz_blank = 1'b0;
        test_reset();
        test_scan();
        test_load_switch();
        test_lz();
        test_hex();
        test_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
